skew_buffer: RTL and testbench
==============================

Name: skew_buffer

Overview:
- Parametrised successor to the fixed triangular skew stage feeding the systolic array.
- Delays N lanes by per-lane staggered amounts, in either direction:
  - skew mode: array input side.
  - deskew mode: array output side, re-aligning results.
- Adds per-lane valid tracking, global stall, mode locking while data is in flight, a busy flag and a drain-complete pulse.
- Sits between the operand/result buffers and the PE grid.

Parameters:
- DATA_WIDTH, 16, bits per lane.
- N, 4, number of lanes (N >= 2); maximum delay is N-1 cycles.
- ZERO_INVALID, 1, when 1 a lane's dout is forced to 0 whenever that lane's dout_valid is 0.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = skew (lane i delayed i cycles); 1 = deskew (lane i delayed N-1-i cycles).
- stall  input  1  1 = hold all stage registers, and in_valid is ignored.
- in_valid  input  1  din beat valid this cycle.
- din  input  N*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- dout  output  N*DATA_WIDTH  delayed lanes, same packing.
- dout_valid  output  N  per-lane valid of dout.
- busy  output  1  1 while any valid beat is held in a stage register.
- drain_done  output  1  one-cycle pulse when the buffer empties.
- mode_q  output  1  mode currently in effect.

Behaviour:
- Reset is sync, active-low; rst_n=0 on a clock edge clears all state:
  - all stage data and stage valid bits, mode_r, busy and drain_done go to 0.
  - Reset mid-operation discards in-flight beats; no drain_done pulse is produced.
- Storage:
  - Each lane i has a shift line of N-1 stages, each stage holding {valid, data}.
  - Stage 0 loads {in_valid & ~stall, in_valid ? din_i : 0}.
  - Stage k loads stage k-1.
  - All stages of all lanes advance together on every cycle with stall=0, and hold on stall=1.
- Lane delay and tap selection:
  - d_i = (mode_eff==0) ? i : N-1-i.
  - d_i = 0: dout_i and dout_valid_i are combinational from din_i and (in_valid & ~stall).
  - d_i = k > 0: output taps stage k-1 (registered).
- Mode locking:
  - mode_eff = busy ? mode_r : mode.
  - mode_r <= mode_eff every cycle (not reset-gated beyond rst_n).
  - mode changes while busy=1 are ignored until the buffer empties.
  - mode_q = mode_eff.
- Valid-to-output timing:
  - A beat accepted at cycle t (in_valid=1, stall=0) appears on lane i at cycle t + d_i + (stall cycles in between), with dout_valid_i=1.
  - Beats are never dropped or duplicated.
- Zero gating:
  - ZERO_INVALID=1: dout_i = 0 when dout_valid_i=0.
  - ZERO_INVALID=0: dout_i shows the raw stage or input value.
- busy: registered; equals the OR of the valid bits of all stages of all lanes after the update, i.e. the OR of next-state valids.
- drain_done: registered; 1 for exactly one cycle, the cycle after busy falls 1->0. A stall does not extend the pulse.
- Back-to-back beats on consecutive cycles are fully pipelined, throughput 1 beat/cycle.
- Simultaneous in_valid=1 and stall=1: the beat is not accepted and the upstream must hold it.
- Full/empty: no overflow condition exists (the structure is a fixed pipeline). busy=0 means empty.
- Widths: no arithmetic; data is passed unmodified.

Test Plan (N=4, DATA_WIDTH=16, ZERO_INVALID=1):
1. Skew single beat.
   - Stimulus: after reset, mode=0, one beat at cycle 0 with din={0x0013,0x0012,0x0011,0x0010} (lane3..lane0).
   - Response: lane0=0x0010 valid at c0; lane1=0x0011 at c1; lane2=0x0012 at c2; lane3=0x0013 at c3. All other lane/cycle outputs are 0 with valid=0. busy=1 during c1..c3. drain_done=1 only at c4.
2. Deskew.
   - Stimulus: same beat with mode=1.
   - Response: lane3 at c0, lane2 at c1, lane1 at c2, lane0 at c3.
3. Streaming.
   - Stimulus: 8 consecutive beats, lane i = 0x0100*beat + i, mode=0.
   - Response: lane i emits beats 0..7 on cycles i..i+7 with no gaps. busy stays 1 from c1 to c10. Exactly one drain_done, at c11.
4. Stall.
   - Stimulus: mode=0, beat at c0, stall=1 during c1..c2.
   - Response: lane3 output delayed to c5 and lane2 to c4. Outputs hold and valid stays stable during the stall. in_valid=1 with stall=1 at c1 produces no beat.
5. Mode lock.
   - Stimulus: mode=0, beat at c0; toggle mode to 1 at c1.
   - Response: mode_q stays 0 through c3 and the skew-mode timing of scenario 1 holds. mode_q=1 from c4.
6. Reset mid-flight.
   - Stimulus: beats at c0..c1; rst_n=0 at c2.
   - Response: from c3, all dout=0, dout_valid=0, busy=0, and no drain_done pulse.

Source files
------------

// File: rtl/skew_buffer_if.sv
// Lane bus between the operand/result buffers, the skew buffer and the PE grid.
// Lanes are packed lane i at [i*DATA_WIDTH +: DATA_WIDTH].
interface skew_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4
);
    logic                    mode;
    logic                    stall;
    logic                    in_valid;
    logic [N*DATA_WIDTH-1:0] din;
    logic [N*DATA_WIDTH-1:0] dout;
    logic [N-1:0]            dout_valid;
    logic                    busy;
    logic                    drain_done;
    logic                    mode_q;

    modport master (
        output mode, stall, in_valid, din,
        input  dout, dout_valid, busy, drain_done, mode_q
    );

    modport slave (
        input  mode, stall, in_valid, din,
        output dout, dout_valid, busy, drain_done, mode_q
    );
endinterface

// File: rtl/skew_buffer.sv
// Per-lane staggered delay line (skew or deskew) with global stall, mode lock
// while data is in flight, busy flag and a one-cycle drain-complete pulse.
module skew_buffer #(
    parameter int DATA_WIDTH   = 16,
    parameter int N            = 4,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    skew_buffer_if.slave bus
);
    logic [DATA_WIDTH-1:0] stage_data  [N][N-1];
    logic                  stage_valid [N][N-1];
    logic [DATA_WIDTH-1:0] data_next   [N][N-1];
    logic                  valid_next  [N][N-1];
    int                    tap         [N];
    logic                  lane_valid  [N];
    logic [DATA_WIDTH-1:0] lane_data   [N];
    logic                  mode_r;
    logic                  busy;
    logic                  busy_next;
    logic                  drain_done;
    logic                  accept;
    logic                  mode_eff;

    assign accept   = bus.in_valid & ~bus.stall;
    // The mode may only change while nothing is in flight.
    assign mode_eff = busy ? mode_r : bus.mode;

    // Every lane shifts through all N-1 stages regardless of its tap, so busy
    // covers a beat until it leaves the last stage.
    always_comb begin
        busy_next = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N-1; k++) begin
                data_next[i][k]  = stage_data[i][k];
                valid_next[i][k] = stage_valid[i][k];
            end
            if (!bus.stall) begin
                valid_next[i][0] = bus.in_valid;
                data_next[i][0]  = bus.in_valid ? bus.din[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k < N-1; k++) begin
                    data_next[i][k]  = stage_data[i][k-1];
                    valid_next[i][k] = stage_valid[i][k-1];
                end
            end
            for (int k = 0; k < N-1; k++) begin
                busy_next = busy_next | valid_next[i][k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N-1; k++) begin
                    stage_data[i][k]  <= '0;
                    stage_valid[i][k] <= 1'b0;
                end
            end
            mode_r     <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            stage_data  <= data_next;
            stage_valid <= valid_next;
            mode_r      <= mode_eff;
            busy        <= busy_next;
            drain_done  <= busy & ~busy_next;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tap[i] = mode_eff ? (N-1-i) : i;
        end
    end

    // Zero-delay lanes bypass the stages; others tap stage (delay-1).
    always_comb begin
        bus.dout       = '0;
        bus.dout_valid = '0;
        for (int i = 0; i < N; i++) begin
            lane_valid[i] = accept;
            lane_data[i]  = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
            for (int k = 1; k < N; k++) begin
                if (tap[i] == k) begin
                    lane_valid[i] = stage_valid[i][k-1];
                    lane_data[i]  = stage_data[i][k-1];
                end
            end
            bus.dout_valid[i] = lane_valid[i];
            bus.dout[i*DATA_WIDTH +: DATA_WIDTH] =
                (ZERO_INVALID && !lane_valid[i]) ? '0 : lane_data[i];
        end
    end

    assign bus.busy       = busy;
    assign bus.drain_done = drain_done;
    assign bus.mode_q     = mode_eff;
endmodule

// File: tb/tb_skew_buffer.sv
// Scoreboard bench for skew_buffer: the stimulus side predicts each beat's
// arrival per lane; a negedge monitor pops and compares.
module tb_skew_buffer;
    localparam int DW = 16;
    localparam int N  = 4;

    typedef struct {
        int          lane;
        int          due;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int   adv;
        logic stall;
        logic busy;
        logic drain;
        logic mode;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    skew_buffer_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    skew_buffer #(.DATA_WIDTH(DW), .N(N), .ZERO_INVALID(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    beat_t beat_q[$];
    rec_t  rec_q[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: adv counts clock edges that shift the pipeline; a beat
    // accepted at adv=a stays somewhere in the stages while adv <= a+N-1.
    int   adv = 0;
    int   last_acc = -100;
    logic mode_hold = 1'b0;
    logic prev_busy = 1'b0;

    task automatic step(input logic m, input logic s, input logic v,
                        input logic [N*DW-1:0] d, input logic r);
        logic busy_m, mode_m, acc, drain_m;
        beat_t b;
        rec_t  rc;
        @(posedge clk);
        #1;
        rst_n = r;
        bus.mode = m;
        bus.stall = s;
        bus.in_valid = v;
        bus.din = d;
        if (!r) begin
            beat_q.delete();
            last_acc = -100;
            mode_hold = 1'b0;
            prev_busy = 1'b0;
        end else begin
            busy_m  = (adv - last_acc) <= (N-1);
            mode_m  = busy_m ? mode_hold : m;
            drain_m = prev_busy & ~busy_m;
            acc     = v & ~s;
            if (acc) begin
                for (int i = 0; i < N; i++) begin
                    b.lane = i;
                    b.due  = adv + (mode_m ? (N-1-i) : i);
                    b.data = d[i*DW +: DW];
                    beat_q.push_back(b);
                end
                last_acc = adv;
            end
            rc.adv = adv; rc.stall = s; rc.busy = busy_m; rc.drain = drain_m; rc.mode = mode_m;
            rec_q.push_back(rc);
            mode_hold = mode_m;
            prev_busy = busy_m;
            if (!s) adv++;
        end
    endtask

    task automatic idle(input logic m, input int n);
        for (int j = 0; j < n; j++) step(m, 1'b0, 1'b0, '0, 1'b1);
    endtask

    always @(negedge clk) begin
        rec_t rc;
        int   idx;
        logic ev;
        logic [DW-1:0] ed;
        if (rec_q.size() > 0) begin
            rc = rec_q.pop_front();
            tests++;
            if (bus.busy !== rc.busy) begin
                fails++;
                $display("FAIL busy @adv%0d: got %b expected %b", rc.adv, bus.busy, rc.busy);
            end
            tests++;
            if (bus.drain_done !== rc.drain) begin
                fails++;
                $display("FAIL drain_done @adv%0d: got %b expected %b", rc.adv, bus.drain_done, rc.drain);
            end
            tests++;
            if (bus.mode_q !== rc.mode) begin
                fails++;
                $display("FAIL mode_q @adv%0d: got %b expected %b", rc.adv, bus.mode_q, rc.mode);
            end
            for (int i = 0; i < N; i++) begin
                idx = -1;
                for (int j = 0; j < beat_q.size(); j++) begin
                    if (idx < 0 && beat_q[j].lane == i) idx = j;
                end
                if (idx >= 0 && beat_q[idx].due < rc.adv) begin
                    tests++;
                    fails++;
                    $display("FAIL lane%0d missed beat: data %h due adv%0d, now adv%0d",
                             i, beat_q[idx].data, beat_q[idx].due, rc.adv);
                    beat_q.delete(idx);
                    idx = -1;
                end
                ev = 1'b0;
                ed = '0;
                if (idx >= 0 && beat_q[idx].due == rc.adv) begin
                    ev = 1'b1;
                    ed = beat_q[idx].data;
                    if (!rc.stall) beat_q.delete(idx);
                end
                tests++;
                if (bus.dout_valid[i] !== ev || bus.dout[i*DW +: DW] !== ed) begin
                    fails++;
                    $display("FAIL lane%0d @adv%0d: got v=%b d=%h expected v=%b d=%h",
                             i, rc.adv, bus.dout_valid[i], bus.dout[i*DW +: DW], ev, ed);
                end
            end
        end
    end

    initial begin
        logic [N*DW-1:0] d;
        logic m;
        bus.mode = 1'b0;
        bus.stall = 1'b0;
        bus.in_valid = 1'b0;
        bus.din = '0;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // single beat, skew then deskew
        step(1'b0, 1'b0, 1'b1, 64'h0013_0012_0011_0010, 1'b1);
        idle(1'b0, 5);
        step(1'b1, 1'b0, 1'b1, 64'h0013_0012_0011_0010, 1'b1);
        idle(1'b1, 5);

        // streaming 8 beats
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < N; i++) d[i*DW +: DW] = 16'(16'h0100 * b + i);
            step(1'b0, 1'b0, 1'b1, d, 1'b1);
        end
        idle(1'b0, 6);

        // stall with a rejected beat
        step(1'b0, 1'b0, 1'b1, 64'h0023_0022_0021_0020, 1'b1);
        step(1'b0, 1'b1, 1'b1, 64'hdead_beef_cafe_f00d, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        idle(1'b0, 6);

        // mode lock
        step(1'b0, 1'b0, 1'b1, 64'h0033_0032_0031_0030, 1'b1);
        idle(1'b1, 6);

        // reset mid-flight
        step(1'b0, 1'b0, 1'b1, 64'h0043_0042_0041_0040, 1'b1);
        step(1'b0, 1'b0, 1'b1, 64'h0053_0052_0051_0050, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b0, 5);

        // randomized traffic
        m = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) m = ~m;
            d = {$urandom, $urandom};
            step(m, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, d,
                 $urandom_range(0, 99) != 0);
        end
        idle(m, 8);

        @(negedge clk);
        #1;
        tests++;
        if (beat_q.size() != 0 || rec_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d beats %0d records pending, expected 0 0",
                     beat_q.size(), rec_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
